// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the MEM stage: access sizes and FSM encodings.
package pipe_mem_pkg;
    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;
endpackage

// File: rtl/pipe_mem_align.sv
// Store lane steering, load extract/extend and misalignment detection.
// Purely combinational.
module mem_align
    import pipe_mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        re,
    input  logic        we,
    input  logic        sext,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);
    logic [7:0]  lb;
    logic [15:0] lh;

    assign lb = rdata[{addr, 3'b000} +: 8];
    assign lh = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be       = 4'b0000;
        wdata    = sdata;
        ldata    = rdata;
        misalign = re & we;
        unique case (1'b1)
            size == MEM_SZ_BYTE: begin
                be    = 4'b0001 << addr;
                wdata = {4{sdata[7:0]}};
                ldata = {{24{sext & lb[7]}}, lb};
            end
            size == MEM_SZ_HALF: begin
                be       = addr[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{sdata[15:0]}};
                ldata    = {{16{sext & lh[15]}}, lh};
                misalign = misalign | addr[0];
            end
            size == MEM_SZ_WORD: begin
                be       = 4'b1111;
                misalign = misalign | (addr != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end
endmodule

// File: rtl/pipe_mem.sv
// MEM stage: req/ack data-memory access, stall control, timeout,
// and the MEM/WB pipeline register.
module pipe_mem
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alud,
    input  logic [31:0] ex_sdata,
    input  logic        ex_mem_re,
    input  logic        ex_mem_we,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_sext,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [31:0] wb_alud,
    output logic [31:0] wb_dmem_data,
    output logic        wb_wdc,
    output logic        wb_wreg,
    output logic [4:0]  wb_rd,
    output logic        err_align,
    output logic        err_bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_e    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          memop, misalign, issue, busy;
    logic          timeout, take;
    logic [3:0]    be;
    logic [31:0]   ldata;

    mem_align u_align (
        .addr     (ex_alud[1:0]),
        .size     (ex_mem_size),
        .re       (ex_mem_re),
        .we       (ex_mem_we),
        .sext     (ex_mem_sext),
        .sdata    (ex_sdata),
        .rdata    (dmem_rdata),
        .be       (be),
        .wdata    (dmem_wdata),
        .ldata    (ldata),
        .misalign (misalign)
    );

    assign memop = ex_valid & (ex_mem_re | ex_mem_we);

    // Gated by rst so the bus request drops without waiting for an edge.
    assign issue = ~rst & (state == ST_IDLE) & memop & ~misalign;
    assign busy  = ~rst & (state == ST_WAIT);

    assign dmem_req  = issue | busy;
    assign dmem_we   = dmem_req & ex_mem_we;
    assign dmem_be   = dmem_req ? be : 4'b0000;
    assign dmem_addr = {ex_alud[31:2], 2'b00};

    assign timeout   = busy & (cnt == CW'(TIMEOUT_CYCLES - 1));
    // A timed-out access retires as a bubble, so upstream may advance.
    assign mem_stall = dmem_req & ~dmem_ack & ~timeout;

    assign take = ((state == ST_IDLE) & ex_valid & ~memop)
                | (dmem_req & dmem_ack);

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        unique case (state)
            ST_IDLE: if (issue & ~dmem_ack) state_nx = ST_WAIT;
            ST_WAIT: begin
                if (dmem_ack | timeout) state_nx = ST_IDLE;
                else cnt_nx = cnt + 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_alud      <= '0;
            wb_dmem_data <= '0;
            wb_wdc       <= 1'b0;
            wb_wreg      <= 1'b0;
            wb_rd        <= '0;
            err_align    <= 1'b0;
            err_bus      <= 1'b0;
        end else begin
            wb_valid     <= take;
            wb_alud      <= take ? ex_alud : '0;
            wb_dmem_data <= (take & ex_mem_re) ? ldata : '0;
            wb_wdc       <= take & ex_mem_re;
            wb_wreg      <= take & ex_wreg;
            wb_rd        <= take ? ex_rd : '0;
            err_align    <= (state == ST_IDLE) & memop & misalign;
            err_bus      <= timeout & ~dmem_ack;
        end
    end
endmodule

// File: tb/tb_pipe_mem.sv
// Directed bench for pipe_mem with a scoreboard of expected MEM/WB slots.
module tb_pipe_mem;
    logic        clk, rst;
    logic        ex_valid, ex_mem_re, ex_mem_we, ex_mem_sext, ex_wreg;
    logic [31:0] ex_alud, ex_sdata;
    logic [1:0]  ex_mem_size;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_ack, mem_stall;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_wdc, wb_wreg, err_align, err_bus;
    logic [31:0] wb_alud, wb_dmem_data;
    logic [4:0]  wb_rd;

    typedef struct {
        logic [31:0] alud;
        logic [31:0] data;
        logic        wdc;
        logic        wreg;
        logic [4:0]  rd;
    } wb_t;

    wb_t q[$];
    int  checks = 0;
    int  errors = 0;

    pipe_mem #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alud(ex_alud), .ex_sdata(ex_sdata),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_mem_size(ex_mem_size), .ex_mem_sext(ex_mem_sext),
        .ex_wreg(ex_wreg), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_alud(wb_alud),
        .wb_dmem_data(wb_dmem_data), .wb_wdc(wb_wdc),
        .wb_wreg(wb_wreg), .wb_rd(wb_rd),
        .err_align(err_align), .err_bus(err_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] sd, input logic re,
                         input logic we, input logic [1:0] sz,
                         input logic sx, input logic wr,
                         input logic [4:0] rd);
        @(negedge clk);
        ex_valid = v; ex_alud = a; ex_sdata = sd;
        ex_mem_re = re; ex_mem_we = we; ex_mem_size = sz;
        ex_mem_sext = sx; ex_wreg = wr; ex_rd = rd;
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic wdc, input logic wr,
                        input logic [4:0] rd);
        wb_t e;
        e.alud = a; e.data = d; e.wdc = wdc; e.wreg = wr; e.rd = rd;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input logic exp_valid);
        wb_t e;
        chk("wb_valid", wb_valid, exp_valid);
        if (exp_valid) begin
            if (q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("wb_alud", wb_alud, e.alud);
                chk("wb_dmem_data", wb_dmem_data, e.data);
                chk("wb_wdc", wb_wdc, e.wdc);
                chk("wb_wreg", wb_wreg, e.wreg);
                chk("wb_rd", wb_rd, e.rd);
            end
        end else begin
            chk("bubble_wreg", wb_wreg, 0);
        end
    endtask

    logic [31:0] bad_a  [4] = '{32'h101, 32'h103, 32'h100, 32'h100};
    logic [1:0]  bad_sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic        bad_we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        dmem_ack = 1'b0; dmem_rdata = '0;
        ex_valid = 0; ex_alud = '0; ex_sdata = '0; ex_mem_re = 0;
        ex_mem_we = 0; ex_mem_size = 2'b10; ex_mem_sext = 0;
        ex_wreg = 0; ex_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_wreg", wb_wreg, 0);
        chk("rst_err_align", err_align, 0);
        chk("rst_err_bus", err_bus, 0);
        chk("rst_req", dmem_req, 0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op
        drive(1, 32'h1234, 0, 0, 0, 2'b10, 0, 1, 5'd5);
        chk("alu_req", dmem_req, 0);
        chk("alu_stall", mem_stall, 0);
        push(32'h1234, 0, 0, 1, 5'd5);
        tick();
        chk_wb(1);

        // LB zero-wait, signed and unsigned
        dmem_rdata = 32'h80AA_BBCC;
        dmem_ack = 1'b1;
        drive(1, 32'h103, 0, 1, 0, 2'b00, 1, 1, 5'd7);
        chk("lb_req", dmem_req, 1);
        chk("lb_we", dmem_we, 0);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_stall", mem_stall, 0);
        push(32'h103, 32'hFFFF_FF80, 1, 1, 5'd7);
        tick();
        chk_wb(1);
        drive(1, 32'h103, 0, 1, 0, 2'b00, 0, 1, 5'd8);
        push(32'h103, 32'h0000_0080, 1, 1, 5'd8);
        tick();
        chk_wb(1);
        drive(1, 32'h102, 0, 1, 0, 2'b01, 1, 1, 5'd9);
        push(32'h102, 32'hFFFF_80AA, 1, 1, 5'd9);
        tick();
        chk_wb(1);

        // SB zero-wait
        drive(1, 32'h101, 32'h5A, 0, 1, 2'b00, 0, 0, 5'd0);
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        push(32'h101, 0, 0, 0, 5'd0);
        tick();
        chk_wb(1);

        // SH with ack after 3 stalled cycles
        dmem_ack = 1'b0;
        drive(1, 32'h202, 32'h0000_BEEF, 0, 1, 2'b01, 0, 0, 5'd3);
        chk("sh_we", dmem_we, 1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_addr, 32'h200);
        for (int i = 0; i < 3; i++) begin
            chk("sh_stall", mem_stall, 1);
            chk("sh_req", dmem_req, 1);
            tick();
            chk_wb(0);
            @(negedge clk);
            #1;
        end
        dmem_ack = 1'b1;
        #1;
        chk("sh_ack_stall", mem_stall, 0);
        push(32'h202, 0, 0, 0, 5'd3);
        tick();
        chk_wb(1);
        dmem_ack = 1'b0;

        // Misaligned / illegal accesses
        for (int i = 0; i < 4; i++) begin
            drive(1, bad_a[i], 0, 1, bad_we[i], bad_sz[i], 0, 1, 5'd4);
            chk("mis_req", dmem_req, 0);
            chk("mis_stall", mem_stall, 0);
            tick();
            chk("mis_err_align", err_align, 1);
            chk_wb(0);
            drive(0, 0, 0, 0, 0, 2'b10, 0, 0, 5'd0);
            tick();
            chk("mis_err_clear", err_align, 0);
        end

        // Timeout: no ack
        drive(1, 32'h400, 0, 1, 0, 2'b10, 0, 1, 5'd6);
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", mem_stall, 1);
            tick();
            chk_wb(0);
            chk("to_no_err", err_bus, 0);
            @(negedge clk);
            #1;
        end
        chk("to_last_stall", mem_stall, 0);
        tick();
        chk("to_err_bus", err_bus, 1);
        chk_wb(0);
        drive(0, 0, 0, 0, 0, 2'b10, 0, 0, 5'd0);
        chk("to_req_low", dmem_req, 0);
        dmem_ack = 1'b1;
        #1;
        chk("late_ack_stall", mem_stall, 0);
        tick();
        chk("to_err_clear", err_bus, 0);
        chk_wb(0);
        dmem_ack = 1'b0;

        // Ack on the last allowed WAIT cycle
        dmem_rdata = 32'h1234_5678;
        drive(1, 32'h400, 0, 1, 0, 2'b10, 0, 1, 5'd9);
        for (int i = 0; i < 4; i++) begin
            chk("la_stall", mem_stall, 1);
            tick();
            chk_wb(0);
            @(negedge clk);
            #1;
        end
        dmem_ack = 1'b1;
        #1;
        chk("la_stall_ack", mem_stall, 0);
        push(32'h400, 32'h1234_5678, 1, 1, 5'd9);
        tick();
        chk_wb(1);
        chk("la_no_err_bus", err_bus, 0);
        dmem_ack = 1'b0;

        // Reset raised mid-WAIT
        drive(1, 32'h500, 0, 1, 0, 2'b10, 0, 1, 5'd2);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_wait_req", dmem_req, 0);
        chk("rst_wait_stall", mem_stall, 0);
        chk("rst_wait_valid", wb_valid, 0);
        chk("rst_wait_wreg", wb_wreg, 0);
        drive(0, 0, 0, 0, 0, 2'b10, 0, 0, 5'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_stall", mem_stall, 0);
        chk("post_rst_req", dmem_req, 0);
        tick();
        chk_wb(0);

        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
